xor_share_sched: RTL

- Round-robin scheduler that shares one single-bit XOR cell between NREQ requesters.
- Each requester submits a WIDTH-bit operand pair (a, b).
- The scheduler grants one requester at a time, streams its operands LSB-first through the shared cell one bit per cycle, reassembles the WIDTH-bit result, and returns it with a one-cycle valid pulse tagged with the requester id.
- Sits between lab-level operand sources (switches/counters) and the shared bit-serial XOR datapath.

---
 rtl/xor_share_sched_pkg.sv | 11 +
 rtl/xor_share_sched_if.sv | 25 ++
 rtl/xor_bit_unit.sv | 8 +
 rtl/xor_share_sched.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/xor_share_sched_pkg.sv
// Shared definitions for the round-robin XOR-cell scheduler.
// State encodings are fixed so the bench can observe the FSM directly.
package xor_share_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/xor_share_sched_if.sv
// Request/operand/result bundle between operand sources and the scheduler.
interface xor_share_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      result;
  logic                  result_valid;
  logic [IDW-1:0]        result_id;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, result, result_valid, result_id
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, result, result_valid, result_id
  );
endinterface

// File: rtl/xor_bit_unit.sv
// Single-bit XOR cell; the one shared datapath resource of the scheduler.
module xor_bit_unit (
  input  logic x_i,
  input  logic y_i,
  output logic z_o
);
  assign z_o = x_i ^ y_i;
endmodule

// File: rtl/xor_share_sched.sv
// Round-robin scheduler streaming one requester's operands LSB-first through a
// shared single-bit XOR cell and returning the reassembled WIDTH-bit result.
module xor_share_sched
  import xor_share_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input logic              clk,
  input logic              rst,
  xor_share_sched_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [IDW-1:0]  LastRst = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] GntOne  = NREQ'(1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-2:0]  res_sh_q, res_sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [IDW-1:0]    result_id_q, result_id_d;
  logic              result_valid_q, result_valid_d;

  logic              pick_found;
  logic [IDW-1:0]    pick_id;
  logic              cell_z;
  logic [WIDTH-1:0]  res_full;

  // Wrap modulo NREQ by explicit compare so non-power-of-two NREQ works.
  function automatic logic [IDW-1:0] rr_index(logic [IDW-1:0] base, int unsigned off);
    int unsigned idx;
    idx = 32'(base) + off;
    if (idx >= NREQ) idx = idx - NREQ;
    return IDW'(idx);
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!pick_found && bus.req[rr_index(last_q, k)]) begin
        pick_found = 1'b1;
        pick_id    = rr_index(last_q, k);
      end
    end
  end

  xor_bit_unit u_xor_bit_unit (
    .x_i (a_sh_q[0]),
    .y_i (b_sh_q[0]),
    .z_o (cell_z)
  );

  assign res_full = {cell_z, res_sh_q};

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    a_sh_d         = a_sh_q;
    b_sh_d         = b_sh_q;
    res_sh_d       = res_sh_q;
    cnt_d          = cnt_q;
    id_d           = id_q;
    last_d         = last_q;
    result_d       = result_q;
    result_id_d    = result_id_q;
    result_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = GntOne << pick_id;
          a_sh_d  = bus.a_in[32'(pick_id) * WIDTH +: WIDTH];
          b_sh_d  = bus.b_in[32'(pick_id) * WIDTH +: WIDTH];
          id_d    = pick_id;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        res_sh_d = res_full[WIDTH-1:1];
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        // Publish on the last shift edge so the valid pulse occupies the DONE cycle.
        if (cnt_q == CntLast) begin
          state_d        = StDone;
          gnt_d          = '0;
          result_d       = res_full;
          result_id_d    = id_q;
          result_valid_d = 1'b1;
          last_d         = id_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      gnt_q          <= '0;
      a_sh_q         <= '0;
      b_sh_q         <= '0;
      res_sh_q       <= '0;
      cnt_q          <= '0;
      id_q           <= '0;
      last_q         <= LastRst;
      result_q       <= '0;
      result_id_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      a_sh_q         <= a_sh_d;
      b_sh_q         <= b_sh_d;
      res_sh_q       <= res_sh_d;
      cnt_q          <= cnt_d;
      id_q           <= id_d;
      last_q         <= last_d;
      result_q       <= result_d;
      result_id_q    <= result_id_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_id    = result_id_q;

endmodule
